program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Streams an instruction image into the 8-bit processor's instruction memory before execution starts.
- Holds the core halted while loading.
- Accepts bytes over a valid/ready handshake and writes them to sequential instruction addresses.
- Verifies an optional trailing 8-bit additive checksum, then releases the core by asserting cpu_run.
- Sits directly upstream of the instruction fetch / program counter path.

Parameters:
- DATA_W, 8, instruction width in bits.
- ADDR_W, 8, instruction address width. Memory depth DEPTH = 2**ADDR_W.
- CHECKSUM_EN, 1. When 1, a checksum beat follows the last instruction beat. When 0, the checksum beat is skipped.

Ports:
- clock, in, 1: rising-edge system clock.
- reset, in, 1: asynchronous, active-high reset.
- load_start, in, 1: begin (or restart) a load.
- in_valid, in, 1: upstream byte valid.
- in_data, in, DATA_W: instruction or checksum byte.
- in_last, in, 1: marks the final instruction byte.
- in_ready, out, 1: loader accepts a beat this cycle.
- imem_we, out, 1: instruction memory write enable.
- imem_addr, out, ADDR_W: instruction memory write address.
- imem_wdata, out, DATA_W: instruction memory write data.
- cpu_run, out, 1: processor may execute. 0 = core held at PC 0.
- load_done, out, 1: a valid image is loaded.
- load_error, out, 1: checksum mismatch or overflow.
- word_count, out, ADDR_W+1: instruction bytes written in the current load.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs 0: imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error, word_count.
  - Internal sum is 0.
  - cpu_run falls immediately, without waiting for a clock edge.
- Beat definition: a beat is accepted on a rising edge where in_valid && in_ready.
- in_ready is combinational: in_ready = (state==LOAD || state==CHECK) && !load_start.
- States: IDLE, LOAD, CHECK, RUN, ERROR.
- IDLE:
  - in_ready=0, cpu_run=0.
  - load_start -> LOAD.
- Entering LOAD from any state:
  - word_count and sum are cleared.
  - load_done, load_error and cpu_run are cleared on the same edge.
- LOAD, accepted beat with word_count < DEPTH:
  - Next cycle: imem_we=1, imem_addr=word_count[ADDR_W-1:0] (pre-increment value), imem_wdata=in_data. Write latency is 1 cycle.
  - word_count is incremented.
  - sum = (sum + in_data) mod 2**DATA_W.
  - If in_last: go to CHECK when CHECKSUM_EN=1, otherwise go to RUN.
- LOAD, accepted beat with word_count == DEPTH (overflow):
  - No write; the address never wraps.
  - Go to ERROR.
- imem_we is 1 only in the cycle after an accepted instruction beat. It is 0 otherwise, including during gaps in in_valid.
- CHECK:
  - The next accepted beat is the checksum. It is never written to memory, and in_last is ignored on it.
  - in_data == sum -> RUN.
  - Otherwise -> ERROR.
- RUN:
  - cpu_run=1, load_done=1, in_ready=0.
  - word_count holds its final value.
  - load_start -> LOAD, with cpu_run falling on that edge.
- ERROR:
  - load_error=1, cpu_run=0, in_ready=0.
  - load_start -> LOAD.
- load_start during LOAD or CHECK:
  - Restarts the load; counters are cleared.
  - in_ready is 0 in that cycle, so no beat is consumed.
  - A write already registered from the previous cycle still completes.
- Minimum image is 1 byte (in_last on the first beat). Maximum image is DEPTH bytes (in_last on beat DEPTH).

Decomposition:
- Shared package (processor_pkg):
  - State encoding localparams: IDLE=0, LOAD=1, CHECK=2, RUN=3, ERROR=4 (3 bits).
  - DATA_W/ADDR_W defaults and the DEPTH constant, so that the fetch, PC and loader stages agree.
- No sub-module: the FSM, counter, accumulator and write register live in one module.

Test Plan:
- Basic load:
  - Stimulus: reset, load_start, then bytes 0x12, 0x34, 0x56 (in_last on 0x56), then checksum 0x9C.
  - Required: writes addr0=0x12, addr1=0x34, addr2=0x56, each one cycle after its beat. Then word_count=3, cpu_run=1, load_done=1.
- Bad checksum:
  - Stimulus: same image with checksum 0x9D.
  - Required: three writes occur, then load_error=1, cpu_run=0, in_ready=0. A following load_start clears load_error.
- Overflow:
  - Stimulus: 257 beats with in_last never asserted.
  - Required: 256 writes to addr 0x00..0xFF, word_count=256. The 257th beat produces no write and the state goes to ERROR.
- Backpressure and restart:
  - Stimulus: in_valid toggles with 2-cycle gaps; load_start is pulsed after 2 beats.
  - Required: imem_we=0 during gaps. in_ready=0 in the restart cycle. The next beat is written at addr 0 and word_count restarts at 1.
- CHECKSUM_EN=0:
  - Stimulus: byte 0xA5 with in_last.
  - Required: write addr0=0xA5, cpu_run=1 on the following edge, and no checksum beat is consumed.
- Async reset:
  - Stimulus: assert reset mid-cycle while in RUN.
  - Required: cpu_run, load_done and word_count drop to 0 before the next clock edge, and the state is IDLE.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the 8-bit processor front end: loader state encoding
// and the instruction memory geometry the fetch, PC and loader stages agree on.
package processor_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int PKG_ADDR_W = 8;
  localparam int DEPTH      = 2 ** PKG_ADDR_W;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

endpackage

// File: rtl/program_loader.sv
// Streams an instruction image into instruction memory over valid/ready, keeps
// the core halted until the image (and optional additive checksum) is accepted.
module program_loader
  import processor_pkg::*;
#(
  parameter int DATA_W      = PKG_DATA_W,
  parameter int ADDR_W      = PKG_ADDR_W,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              overflow;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

  function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign accept   = in_valid && in_ready;
  assign overflow = word_count[ADDR_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load_start) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (overflow)     state_nx = ERROR;
            else if (in_last) state_nx = CHECKSUM_EN ? CHECK : RUN;
          end
        end
        CHECK: begin
          // The checksum beat's in_last is deliberately ignored.
          if (accept) state_nx = (in_data == sum) ? RUN : ERROR;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Run/done/error decode straight from state so an async reset drops cpu_run at once.
  always_comb begin
    in_ready   = ((state == LOAD) || (state == CHECK)) && !load_start;
    cpu_run    = (state == RUN);
    load_done  = (state == RUN);
    load_error = (state == ERROR);
  end

  // Stage p1: registered memory write, one cycle after the accepted beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      word_count <= '0;
      sum        <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (load_start) begin
        word_count <= '0;
        sum        <= '0;
      end else if (accept && (state == LOAD) && !overflow) begin
        vld_p1     <= 1'b1;
        addr_p1    <= word_count[ADDR_W-1:0];
        wdata_p1   <= in_data;
        word_count <= word_count + COUNT_ONE;
        sum        <= sum_add(sum, in_data);
      end
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go into a scoreboard
// queue when a beat is driven and are popped when the loader writes memory.
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, imem_we, cpu_run, load_done, load_error;
  logic [7:0] imem_addr, imem_wdata;
  logic [8:0] word_count;

  logic       ld0_start = 1'b0;
  logic       v0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       l0 = 1'b0;
  logic       in_ready0, imem_we0, cpu_run0, load_done0, load_error0;
  logic [7:0] imem_addr0, imem_wdata0;
  logic [8:0] word_count0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_addr = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;
  wr_t sb[$];

  program_loader #(.DATA_W(8), .ADDR_W(8), .CHECKSUM_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .load_done(load_done), .load_error(load_error), .word_count(word_count)
  );

  program_loader #(.DATA_W(8), .ADDR_W(8), .CHECKSUM_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .load_start(ld0_start), .in_valid(v0),
    .in_data(d0), .in_last(l0), .in_ready(in_ready0), .imem_we(imem_we0),
    .imem_addr(imem_addr0), .imem_wdata(imem_wdata0), .cpu_run(cpu_run0),
    .load_done(load_done0), .load_error(load_error0), .word_count(word_count0)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every memory write must match the oldest expected write, in the expected cycle.
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (sb.size() == 0) begin
        check("spurious_write", {24'h0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {24'h0, imem_addr}, {24'h0, e.addr});
        check("wr_data", {24'h0, imem_wdata}, {24'h0, e.data});
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic l, input bit wr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("beat_timeout", {31'h0, in_ready}, 32'h1);
    if (wr) begin
      sb.push_back('{addr: exp_addr[7:0], data: d, cyc: cyc + 1});
      exp_addr++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_load();
    @(posedge clock);
    #1 load_start = 1'b1;
    @(posedge clock);
    #1 load_start = 1'b0;
    exp_addr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("rst_we", {31'h0, imem_we}, 32'h0);
    check("rst_word_count", {23'h0, word_count}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b0;

    // Basic load with a correct checksum (0x12+0x34+0x56 = 0x9C).
    start_load();
    beat(8'h12, 1'b0, 1'b1);
    beat(8'h34, 1'b0, 1'b1);
    beat(8'h56, 1'b1, 1'b1);
    check("basic_check_state_ready", {31'h0, in_ready}, 32'h1);
    beat(8'h9C, 1'b1, 1'b0);
    check("basic_word_count", {23'h0, word_count}, 32'd3);
    check("basic_cpu_run", {31'h0, cpu_run}, 32'h1);
    check("basic_load_done", {31'h0, load_done}, 32'h1);
    check("basic_in_ready", {31'h0, in_ready}, 32'h0);

    // Asynchronous reset mid-cycle while running.
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("arst_load_done", {31'h0, load_done}, 32'h0);
    check("arst_word_count", {23'h0, word_count}, 32'h0);
    check("arst_state", {29'h0, dut.state}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Bad checksum.
    start_load();
    beat(8'h12, 1'b0, 1'b1);
    beat(8'h34, 1'b0, 1'b1);
    beat(8'h56, 1'b1, 1'b1);
    beat(8'h9D, 1'b0, 1'b0);
    check("badck_load_error", {31'h0, load_error}, 32'h1);
    check("badck_cpu_run", {31'h0, cpu_run}, 32'h0);
    check("badck_in_ready", {31'h0, in_ready}, 32'h0);
    start_load();
    check("badck_error_cleared", {31'h0, load_error}, 32'h0);
    check("badck_reload_count", {23'h0, word_count}, 32'h0);

    // Backpressure with 2-cycle gaps, then a restart after 2 beats.
    beat(8'hA1, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    beat(8'hA2, 1'b0, 1'b1);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    @(negedge clock);
    check("restart_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clock);
    #1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    exp_addr   = 0;
    check("restart_word_count", {23'h0, word_count}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    beat(8'h33, 1'b0, 1'b1);
    check("restart_next_count", {23'h0, word_count}, 32'd1);

    // Overflow: 257 beats, in_last never set.
    start_load();
    for (int i = 0; i < 256; i++) beat(8'(i ^ 8'h5A), 1'b0, 1'b1);
    check("ovf_count_full", {23'h0, word_count}, 32'd256);
    beat(8'hEE, 1'b0, 1'b0);
    check("ovf_count_hold", {23'h0, word_count}, 32'd256);
    check("ovf_load_error", {31'h0, load_error}, 32'h1);
    check("ovf_state", {29'h0, dut.state}, 32'd4);
    repeat (2) @(posedge clock);
    #1;

    // CHECKSUM_EN=0 instance: single-byte image goes straight to RUN.
    ld0_start = 1'b1;
    @(posedge clock);
    #1 ld0_start = 1'b0;
    v0 = 1'b1;
    d0 = 8'hA5;
    l0 = 1'b1;
    @(negedge clock);
    check("nock_ready", {31'h0, in_ready0}, 32'h1);
    @(posedge clock);
    #1;
    d0 = 8'h5A;
    check("nock_we", {31'h0, imem_we0}, 32'h1);
    check("nock_addr", {24'h0, imem_addr0}, 32'h0);
    check("nock_data", {24'h0, imem_wdata0}, 32'hA5);
    check("nock_cpu_run", {31'h0, cpu_run0}, 32'h1);
    check("nock_no_ck_ready", {31'h0, in_ready0}, 32'h0);
    @(posedge clock);
    #1;
    v0 = 1'b0;
    l0 = 1'b0;
    check("nock_word_count", {23'h0, word_count0}, 32'd1);
    check("nock_still_run", {31'h0, load_done0}, 32'h1);
    check("nock_no_second_we", {31'h0, imem_we0}, 32'h0);

    repeat (3) @(posedge clock);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
